ucsbece154a_dmem_responder: RTL and testbench

Wait-stated data-memory responder for the ucsbece154a RISC-V core. It sits on the core's load/store port in place of the zero-latency data RAM and accepts one request at a time over a valid/ready handshake. It inserts a programmable number of wait states, then returns read data or a write acknowledgement, with an error flag for misaligned or out-of-range accesses. It gives the multi-cycle and pipelined cores a realistic memory to stall against.

---
 rtl/ucsbece154a_dmem_responder.sv | 124 ++++++++++++
 tb/tb_ucsbece154a_dmem_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154a_dmem_responder.sv
// Wait-stated data-memory responder: one request at a time over valid/ready,
// LATENCY wait states, then a registered load/store response with an error flag.
module ucsbece154a_dmem_responder #(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    state_t             state_q, state_d;
    req_t               req_q, req_in, req_cur;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        rdata_q;
    logic               err_q;
    logic               accept, commit;
    logic [31:0]        offset, word_off;
    logic [IDX_W-1:0]   idx;
    logic               err_cur;
    logic [31:0]        mem [DEPTH_WORDS];

    assign req_in  = '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i, be: req_be_i};
    assign accept  = req_valid_i && (state_q == S_IDLE);

    // With LATENCY==0 the commit happens on the accepting edge, so decode
    // straight from the inputs while idle; otherwise from the latched request.
    assign req_cur  = (state_q == S_IDLE) ? req_in : req_q;
    assign offset   = req_cur.addr - BASE_ADDR;
    assign word_off = offset >> 2;
    assign idx      = word_off[IDX_W-1:0];
    assign err_cur  = (req_cur.addr[1:0] != 2'b00) || (word_off >= 32'(DEPTH_WORDS));

    assign req_ready_o  = (state_q == S_IDLE);
    assign resp_valid_o = (state_q == S_RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

    // Next-state decode; commit marks the edge that enters RESP.
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    if (LATENCY == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(LATENCY - 1)) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, request latch, wait counter and registered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_q <= req_in;
                cnt_q <= '0;
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (commit) begin
                rdata_q <= (err_cur || req_cur.we) ? 32'h0 : mem[idx];
                err_q   <= err_cur;
            end else if ((state_q == S_RESP) && resp_ready_i) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    // Byte-masked store on commit; array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!reset && commit && req_cur.we && !err_cur) begin
            for (int b = 0; b < 4; b++) begin
                if (req_cur.be[b]) mem[idx][8*b +: 8] <= req_cur.wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ucsbece154a_dmem_responder.sv
// Self-checking bench: table vectors, multi-cycle corner sequences and random
// traffic against an array-based memory model.
module tb_ucsbece154a_dmem_responder;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          LAT   = 2;

    logic        clk = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, sel = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        v0, v1, rdy0, rdy1, rv0, rv1, er0, er1;
    logic [31:0] rd0, rd1;
    logic        rdy, rv, er;
    logic [31:0] rd;

    always #5 clk = ~clk;

    assign v0  = req_valid & ~sel;
    assign v1  = req_valid & sel;
    assign rdy = sel ? rdy1 : rdy0;
    assign rv  = sel ? rv1  : rv0;
    assign rd  = sel ? rd1  : rd0;
    assign er  = sel ? er1  : er0;

    ucsbece154a_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid_i(v0), .req_ready_o(rdy0),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .resp_valid_o(rv0), .resp_ready_i(resp_ready), .resp_rdata_o(rd0), .resp_err_o(er0));

    ucsbece154a_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid_i(v1), .req_ready_o(rdy1),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .resp_valid_o(rv1), .resp_ready_i(resp_ready), .resp_rdata_o(rd1), .resp_err_o(er1));

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference memory: word-addressed array, error rule from plain arithmetic.
    logic [31:0] model [DEPTH];

    task automatic ref_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, output logic [31:0] rdx, output logic ex);
        logic [31:0] off;
        off = addr - BASE;
        ex  = (addr % 4 != 0) || (off / 4 >= DEPTH);
        rdx = 32'h0;
        if (!ex) begin
            if (we) begin
                for (int k = 0; k < 4; k++)
                    if (be[k]) model[off/4][8*k +: 8] = wdata[8*k +: 8];
            end else begin
                rdx = model[off/4];
            end
        end
    endtask

    // One complete transaction, called and returning at a negedge.
    task automatic txn(input logic s, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int lat_exp,
                       output logic [31:0] rdx, output logic ex);
        int t, lat;
        sel = s; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        req_valid = 1'b1;
        t = 0;
        while (!rdy && t < 50) begin @(negedge clk); t++; end
        if (!rdy) chk("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rv && lat < 50) begin @(negedge clk); lat++; end
        chk("latency", 32'(lat), 32'(lat_exp));
        rdx = rd; ex = er;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("ready_after_hs", {31'd0, rdy}, 32'd1);
        chk("valid_after_hs", {31'd0, rv}, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] off;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[13];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rdx, mrd, hold_rd;
        logic        ex, mer, hold_er;
        logic [31:0] a;
        int          t, lat, r;

        vecs[0]  = '{1'b1, 32'd8,   32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'd8,   32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'd4,   32'h1122_3344, 4'hF, 32'h0,         1'b0};
        vecs[3]  = '{1'b1, 32'd4,   32'hAABB_CCDD, 4'h5, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, 32'd4,   32'h0,         4'hF, 32'h11BB_33DD, 1'b0};
        vecs[5]  = '{1'b0, 32'd6,   32'h0,         4'hF, 32'h0,         1'b1};
        vecs[6]  = '{1'b1, 32'd256, 32'h7,         4'hF, 32'h0,         1'b1};
        vecs[7]  = '{1'b0, 32'd0,   32'h0,         4'h0, 32'hA500_0000, 1'b0};
        vecs[8]  = '{1'b0, 32'd252, 32'h0,         4'h0, 32'hA500_003F, 1'b0};
        vecs[9]  = '{1'b1, 32'd12,  32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0};
        vecs[10] = '{1'b0, 32'd12,  32'h0,         4'h0, 32'hA500_0003, 1'b0};
        vecs[11] = '{1'b1, 32'd8,   32'h0,         4'h8, 32'h0,         1'b0};
        vecs[12] = '{1'b0, 32'd8,   32'h0,         4'h0, 32'h00AD_BEEF, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready",  {31'd0, rdy0}, 32'd1);
        chk("rst_valid",  {31'd0, rv0},  32'd0);
        chk("rst_rdata",  rd0,           32'd0);
        chk("rst_err",    {31'd0, er0},  32'd0);
        chk("rst_ready1", {31'd0, rdy1}, 32'd1);

        // Known contents in every word
        for (int i = 0; i < DEPTH; i++) begin
            ref_txn(1'b1, BASE + 4*i, 32'hA500_0000 | i, 4'hF, mrd, mer);
            txn(1'b0, 1'b1, BASE + 4*i, 32'hA500_0000 | i, 4'hF, LAT + 1, rdx, ex);
        end

        // Table vectors
        for (int i = 0; i < 13; i++) begin
            ref_txn(vecs[i].we, BASE + vecs[i].off, vecs[i].wdata, vecs[i].be, mrd, mer);
            txn(1'b0, vecs[i].we, BASE + vecs[i].off, vecs[i].wdata, vecs[i].be, LAT + 1, rdx, ex);
            chk($sformatf("vec%0d_rdata", i), rdx, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), {31'd0, ex}, {31'd0, vecs[i].exp_err});
        end

        // Stalled response with a pending request behind it
        sel = 1'b0; req_we = 1'b1; req_addr = BASE + 20; req_wdata = 32'h1234_5678; req_be = 4'hF;
        req_valid = 1'b1;
        ref_txn(1'b1, BASE + 20, 32'h1234_5678, 4'hF, mrd, mer);
        @(negedge clk);
        req_we = 1'b0;
        t = 0;
        while (!rv0 && t < 50) begin @(negedge clk); t++; end
        chk("stall_reach_resp", {31'd0, rv0}, 32'd1);
        hold_rd = rd0; hold_er = er0;
        chk("stall_err", {31'd0, hold_er}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, rv0}, 32'd1);
            chk("stall_rdata", rd0, hold_rd);
            chk("stall_ready", {31'd0, rdy0}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("stall_hs_ready", {31'd0, rdy0}, 32'd1);
        @(negedge clk);
        chk("stall_next_accepted", {31'd0, rdy0}, 32'd0);
        req_valid = 1'b0;
        lat = 1;
        while (!rv0 && lat < 50) begin @(negedge clk); lat++; end
        chk("stall_next_latency", 32'(lat), 32'(LAT + 1));
        chk("stall_next_rdata", rd0, 32'h1234_5678);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;

        // Reset during WAIT abandons the store
        req_we = 1'b1; req_addr = BASE; req_wdata = 32'h55; req_be = 4'hF; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("wait_state_entered", {31'd0, rdy0}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstw_ready", {31'd0, rdy0}, 32'd1);
        chk("rstw_valid", {31'd0, rv0},  32'd0);
        chk("rstw_rdata", rd0,           32'd0);
        chk("rstw_err",   {31'd0, er0},  32'd0);
        txn(1'b0, 1'b0, BASE, 32'h0, 4'h0, LAT + 1, rdx, ex);
        chk("rstw_old_value", rdx, model[0]);

        // Reset during RESP keeps the committed store
        req_we = 1'b1; req_addr = BASE + 4; req_wdata = 32'h66; req_be = 4'hF; req_valid = 1'b1;
        ref_txn(1'b1, BASE + 4, 32'h66, 4'hF, mrd, mer);
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (!rv0 && t < 50) begin @(negedge clk); t++; end
        chk("rstr_reach_resp", {31'd0, rv0}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstr_valid", {31'd0, rv0}, 32'd0);
        chk("rstr_ready", {31'd0, rdy0}, 32'd1);
        txn(1'b0, 1'b0, BASE + 4, 32'h0, 4'h0, LAT + 1, rdx, ex);
        chk("rstr_committed", rdx, 32'h66);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = BASE + 4 * $urandom_range(0, DEPTH - 1);
            else if (r == 7) a = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
            else if (r == 8) a = BASE + 4 * (DEPTH + $urandom_range(0, 1000));
            else             a = BASE - 4 * $urandom_range(1, 100);
            req_we    = 1'($urandom_range(0, 1));
            req_wdata = $urandom;
            req_be    = 4'($urandom_range(0, 15));
            ref_txn(req_we, a, req_wdata, req_be, mrd, mer);
            txn(1'b0, req_we, a, req_wdata, req_be, LAT + 1, rdx, ex);
            chk($sformatf("rnd%0d_rdata", i), rdx, mrd);
            chk($sformatf("rnd%0d_err", i), {31'd0, ex}, {31'd0, mer});
        end

        // Zero-latency instance
        txn(1'b1, 1'b1, 32'h60, 32'h19, 4'hF, 1, rdx, ex);
        chk("lat0_store_err", {31'd0, ex}, 32'd0);
        txn(1'b1, 1'b0, 32'h60, 32'h0, 4'h0, 1, rdx, ex);
        chk("lat0_load_rdata", rdx, 32'h19);
        chk("lat0_load_err", {31'd0, ex}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
